// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and control-vector bit positions for pipeline stage registers.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    localparam int CTRL_HALT     = 0;
    localparam int CTRL_WREG_LSB = 1;
    localparam int CTRL_PCS      = 5;
    localparam int CTRL_MEMTOREG = 6;
    localparam int CTRL_REGWRITE = 7;

endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one beat register (ctrl + data) with write-enable, synchronous clear and async active-low reset.
module pipe_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_we,
    input  logic         i_clr,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or negedge rst)
        if (!rst)
            r_q <= '0;
        else if (i_clr)
            r_q <= '0;
        else if (i_we)
            r_q <= i_d;

    assign o_q = r_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: elastic pipeline register with one-entry skid buffer, flush, bubble gating and halt drain.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W         = 16,
    parameter int NDATA          = 3,
    parameter int CTRL_W         = 8,
    parameter int HALT_BIT       = CTRL_HALT,
    parameter int CLEAR_ON_FLUSH = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CTRL_W-1:0]       in_ctrl,
    input  logic [NDATA*DATA_W-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CTRL_W-1:0]       out_ctrl,
    output logic [NDATA*DATA_W-1:0] out_data,
    input  logic                    flush,
    output logic                    halted
);

    localparam int DW = NDATA * DATA_W;
    localparam int W  = CTRL_W + DW;

    state_t         r_state;
    logic           r_halt_seen;
    logic           w_skid_valid;
    logic           w_in_xfer;
    logic           w_main_we;
    logic           w_skid_we;
    logic           w_clr;
    logic [W-1:0]   w_main_d;
    logic [W-1:0]   w_main_q;
    logic [W-1:0]   w_skid_q;

    assign out_valid    = r_state != EMPTY;
    assign w_skid_valid = r_state == SKID;
    assign in_ready     = !w_skid_valid && !r_halt_seen;
    assign w_in_xfer    = in_valid && in_ready;
    assign w_clr        = flush && (CLEAR_ON_FLUSH != 0);

    // Main reloads from skid when draining, otherwise from the input when it is free or emptying.
    assign w_main_we = !flush && (w_skid_valid ? out_ready
                                               : w_in_xfer && (r_state == EMPTY || out_ready));
    assign w_skid_we = !flush && r_state == FULL && w_in_xfer && !out_ready;
    assign w_main_d  = w_skid_valid ? w_skid_q : {in_ctrl, in_data};

    pipe_slot #(.W(W)) u_main (
        .clk   (clk),
        .rst   (rst),
        .i_we  (w_main_we),
        .i_clr (w_clr),
        .i_d   (w_main_d),
        .o_q   (w_main_q)
    );

    pipe_slot #(.W(W)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .i_we  (w_skid_we),
        .i_clr (w_clr),
        .i_d   ({in_ctrl, in_data}),
        .o_q   (w_skid_q)
    );

    // Gate control bits so an empty stage never asserts regWrite downstream.
    assign out_ctrl = w_main_q[W-1 -: CTRL_W] & {CTRL_W{out_valid}};
    assign out_data = w_main_q[DW-1:0];
    assign halted   = r_halt_seen && !out_valid && !w_skid_valid;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            r_state     <= EMPTY;
            r_halt_seen <= 1'b0;
        end else if (flush) begin
            r_state     <= EMPTY;
            r_halt_seen <= 1'b0;
        end else begin
            if (w_in_xfer && in_ctrl[HALT_BIT])
                r_halt_seen <= 1'b1;
            case (r_state)
                EMPTY:   if (w_in_xfer) r_state <= FULL;
                FULL:    if (w_in_xfer && !out_ready) r_state <= SKID;
                         else if (!w_in_xfer && out_ready) r_state <= EMPTY;
                SKID:    if (out_ready) r_state <= FULL;
                default: r_state <= EMPTY;
            endcase
        end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: table-driven handshake checks with a beat scoreboard for pipe_stage_skid.
module tb_pipe_stage_skid;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_ctrl = '0;
    logic [47:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_ctrl;
    logic [47:0] out_data;
    logic        flush = 1'b0;
    logic        halted;

    pipe_stage_skid dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .flush     (flush),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [7:0]  c;
        logic [15:0] d;
        logic        ordy;
        logic        fl;
        logic        ir;
        logic        ov;
        logic        hl;
    } vec_t;

    typedef struct {
        logic [7:0]  c;
        logic [15:0] d;
    } beat_t;

    localparam logic [7:0] C = 8'h82;

    vec_t        tv[$];
    beat_t       sb[$];
    logic [15:0] last;
    logic        exp_ir;
    int          n_vec = 0;
    int          n_err = 0;

    function automatic vec_t v(input logic iv, input logic [7:0] c, input logic [15:0] d,
                               input logic ordy, input logic fl,
                               input logic ir, input logic ov, input logic hl);
        vec_t r;
        r = '{iv, c, d, ordy, fl, ir, ov, hl};
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_data();
        if (sb.size() > 0) begin
            chk("out_ctrl", 64'(out_ctrl), 64'(sb[0].c));
            chk("out_data", 64'(out_data), 64'({3{sb[0].d}}));
        end else begin
            chk("bubble_ctrl", 64'(out_ctrl), 64'd0);
            chk("idle_data", 64'(out_data), 64'({3{last}}));
        end
    endtask

    task automatic step(input vec_t t);
        beat_t b;
        in_valid  = t.iv;
        in_ctrl   = t.c;
        in_data   = {3{t.d}};
        out_ready = t.ordy;
        flush     = t.fl;
        check_data();
        if (t.fl) begin
            sb.delete();
            last = '0;
        end else begin
            if (sb.size() > 0 && t.ordy) begin
                last = sb[0].d;
                void'(sb.pop_front());
            end
            if (t.iv && exp_ir) begin
                b = '{t.c, t.d};
                sb.push_back(b);
            end
        end
        @(posedge clk);
        #1;
        chk("in_ready", 64'(in_ready), 64'(t.ir));
        chk("out_valid", 64'(out_valid), 64'(t.ov));
        chk("halted", 64'(halted), 64'(t.hl));
        exp_ir = t.ir;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // streaming
        for (int k = 1; k <= 8; k++) tv.push_back(v(1, C, 16'(k), 1, 0, 1, 1, 0));
        tv.push_back(v(0, 0, 0, 1, 0, 1, 0, 0));
        // skid absorbs a stalled beat
        tv.push_back(v(1, C, 16'hA5A5, 0, 0, 1, 1, 0));
        tv.push_back(v(1, C, 16'h5A5A, 0, 0, 0, 1, 0));
        tv.push_back(v(1, C, 16'h1111, 0, 0, 0, 1, 0));
        tv.push_back(v(0, 0, 0, 1, 0, 1, 1, 0));
        tv.push_back(v(0, 0, 0, 1, 0, 1, 0, 0));
        // single-cycle downstream stall
        tv.push_back(v(1, C, 16'h0601, 1, 0, 1, 1, 0));
        tv.push_back(v(1, C, 16'h0602, 0, 0, 0, 1, 0));
        tv.push_back(v(1, C, 16'h0603, 1, 0, 1, 1, 0));
        tv.push_back(v(1, C, 16'h0603, 1, 0, 1, 1, 0));
        tv.push_back(v(0, 0, 0, 1, 0, 1, 0, 0));
        // flush with skid full and a beat offered
        tv.push_back(v(1, C, 16'h0101, 0, 0, 1, 1, 0));
        tv.push_back(v(1, C, 16'h0202, 0, 0, 0, 1, 0));
        tv.push_back(v(1, C, 16'hBEEF, 0, 1, 1, 0, 0));
        tv.push_back(v(0, 0, 0, 1, 0, 1, 0, 0));
        tv.push_back(v(0, 0, 0, 0, 0, 1, 0, 0));
        // flush together with an output transfer
        tv.push_back(v(1, C, 16'h0303, 1, 0, 1, 1, 0));
        tv.push_back(v(0, 0, 0, 1, 1, 1, 0, 0));
        tv.push_back(v(0, 0, 0, 0, 0, 1, 0, 0));
        // halt drain
        tv.push_back(v(1, 8'h01, 16'h7001, 0, 0, 0, 1, 0));
        tv.push_back(v(1, C, 16'h7002, 0, 0, 0, 1, 0));
        tv.push_back(v(1, C, 16'h7003, 0, 0, 0, 1, 0));
        tv.push_back(v(1, C, 16'h7004, 1, 0, 0, 0, 1));
        tv.push_back(v(0, 0, 0, 1, 0, 0, 0, 1));
        tv.push_back(v(0, 0, 0, 0, 1, 1, 0, 0));
        // halt beat discarded by flush
        tv.push_back(v(1, 8'h01, 16'h7777, 1, 1, 1, 0, 0));
        tv.push_back(v(1, C, 16'h0404, 1, 0, 1, 1, 0));
        tv.push_back(v(0, 0, 0, 1, 0, 1, 0, 0));
        // bubble gating after an all-ones control beat
        tv.push_back(v(1, 8'hFF, 16'h0505, 0, 0, 0, 1, 0));
        tv.push_back(v(0, 0, 0, 1, 0, 0, 0, 1));
        tv.push_back(v(0, 0, 0, 0, 1, 1, 0, 0));
        tv.push_back(v(0, 0, 0, 0, 0, 1, 0, 0));

        last   = '0;
        exp_ir = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_halted", 64'(halted), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        foreach (tv[i]) step(tv[i]);

        // asynchronous reset with both slots full
        step(v(1, C, 16'h0A0A, 0, 0, 1, 1, 0));
        step(v(1, C, 16'h0B0B, 0, 0, 0, 1, 0));
        in_valid = 1'b0;
        #3 rst = 1'b0;
        #1;
        chk("amid_out_valid", 64'(out_valid), 64'd0);
        chk("amid_out_ctrl", 64'(out_ctrl), 64'd0);
        chk("amid_out_data", 64'(out_data), 64'd0);
        chk("amid_in_ready", 64'(in_ready), 64'd1);
        chk("amid_halted", 64'(halted), 64'd0);
        sb.delete();
        last   = '0;
        exp_ir = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) step(v(0, 0, 0, 1, 0, 1, 0, 0));
        step(v(1, C, 16'h0C0C, 1, 0, 1, 1, 0));
        step(v(0, 0, 0, 1, 0, 1, 0, 0));
        step(v(0, 0, 0, 0, 0, 1, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
